// File: rtl/rgb_hue_importance_if.sv
// Pixel-in / hue+importance-out bundle between the pixel source and the hue histogram.
interface rgb_hue_importance_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  r;
  logic [7:0]  g;
  logic [7:0]  b;
  logic        out_valid;
  logic [8:0]  hue;
  logic [47:0] importance;

  modport master (
    output in_valid, r, g, b,
    input  in_ready, out_valid, hue, importance
  );

  modport slave (
    input  in_valid, r, g, b,
    output in_ready, out_valid, hue, importance
  );
endinterface

// File: rtl/rgb_hue_importance.sv
// RGB pixel to hue (degrees) and chroma*max importance weight, using a 14-cycle
// restoring divider; fixed 17-cycle latency from acceptance to out_valid.
module rgb_hue_importance #(
  parameter int unsigned IMP_SHIFT  = 0,
  parameter int unsigned MIN_CHROMA = 0
) (
  input logic                 clk,
  input logic                 reset,
  rgb_hue_importance_if.slave px
);

  typedef enum logic [1:0] {IDLE, PREP, DIV, DONE} state_t;

  state_t      state;
  logic [7:0]  r_q, g_q, b_q;
  logic [7:0]  c_q, max_q, div_q;
  logic [8:0]  off_q;
  logic        neg_q;
  logic [7:0]  rem_q;
  logic [13:0] quo_q;
  logic [3:0]  cnt_q;
  logic        out_valid_q;
  logic [8:0]  hue_q;
  logic [47:0] imp_q;

  // PREP datapath
  logic [7:0]  mx, mn, c, pa, pb, absd, dv;
  logic [8:0]  off;
  logic        r_dom, g_dom, neg;
  logic [13:0] num;

  always_comb begin
    mx    = r_q;
    mn    = r_q;
    if (g_q > mx) mx = g_q;
    if (b_q > mx) mx = b_q;
    if (g_q < mn) mn = g_q;
    if (b_q < mn) mn = b_q;
    c     = mx - mn;
    r_dom = (r_q >= g_q) && (r_q >= b_q);
    g_dom = !r_dom && (g_q >= b_q);
    if (r_dom) begin
      off = 9'd0;   pa = g_q; pb = b_q;
    end else if (g_dom) begin
      off = 9'd120; pa = b_q; pb = r_q;
    end else begin
      off = 9'd240; pa = r_q; pb = g_q;
    end
    neg  = pa < pb;
    absd = neg ? (pb - pa) : (pa - pb);
    num  = {6'b0, absd} * 14'd60;
    dv   = (c == 8'd0) ? 8'd1 : c;
  end

  // One restoring-division step: quotient bits shift in at the bottom of quo_q
  // while the numerator bits shift out of the top.
  logic [8:0] rem_sh;
  logic       ge;
  logic [7:0] rem_nx;

  always_comb begin
    rem_sh = {rem_q, quo_q[13]};
    ge     = rem_sh >= {1'b0, div_q};
    rem_nx = ge ? 8'(rem_sh - {1'b0, div_q}) : rem_sh[7:0];
  end

  // DONE datapath
  logic [8:0]  q9, hue_nx;
  logic [15:0] prod;
  logic [47:0] imp_nx;

  always_comb begin
    q9   = quo_q[8:0];
    prod = {8'b0, c_q} * {8'b0, max_q};
    if (c_q == 8'd0)
      hue_nx = 9'd0;
    else if (!neg_q)
      hue_nx = off_q + q9;
    else if (off_q == 9'd0)
      hue_nx = (q9 == 9'd0) ? 9'd0 : (9'd360 - q9);
    else
      hue_nx = off_q - q9;
    if ((c_q == 8'd0) || (32'(c_q) < MIN_CHROMA))
      imp_nx = '0;
    else
      imp_nx = {32'b0, prod} << IMP_SHIFT;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      out_valid_q <= 1'b0;
      hue_q       <= '0;
      imp_q       <= '0;
      cnt_q       <= '0;
    end else begin
      out_valid_q <= 1'b0;
      imp_q       <= '0;
      case (state)
        IDLE: begin
          if (px.in_valid) begin
            r_q   <= px.r;
            g_q   <= px.g;
            b_q   <= px.b;
            state <= PREP;
          end
        end
        PREP: begin
          c_q   <= c;
          max_q <= mx;
          off_q <= off;
          neg_q <= neg;
          div_q <= dv;
          quo_q <= num;
          rem_q <= '0;
          cnt_q <= '0;
          state <= DIV;
        end
        DIV: begin
          rem_q <= rem_nx;
          quo_q <= {quo_q[12:0], ge};
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == 4'd13) state <= DONE;
        end
        DONE: begin
          hue_q       <= hue_nx;
          imp_q       <= imp_nx;
          out_valid_q <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign px.in_ready   = (state == IDLE) && !reset;
  assign px.out_valid  = out_valid_q;
  assign px.hue        = hue_q;
  assign px.importance = imp_q;

endmodule

// File: tb/tb_rgb_hue_importance.sv
// Scoreboard bench: accepted pixels push model results; per-DUT monitors pop on out_valid.
module tb_rgb_hue_importance;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  rgb_hue_importance_if ifa ();
  rgb_hue_importance_if ifb ();

  rgb_hue_importance #(.IMP_SHIFT(0), .MIN_CHROMA(0)) dut_a (
    .clk(clk), .reset(reset), .px(ifa.slave)
  );
  rgb_hue_importance #(.IMP_SHIFT(32), .MIN_CHROMA(16)) dut_b (
    .clk(clk), .reset(reset), .px(ifb.slave)
  );

  typedef struct {
    int              hue;
    longint unsigned imp;
    int              stamp;
  } exp_t;

  exp_t exq_a[$];
  exp_t exq_b[$];
  int   accq[$];
  int   cyc = 0;
  int   compared = 0;
  int   failed = 0;

  // Reference: HSV-style hue from the dominant channel, integer-floored sector fraction.
  function automatic exp_t model(input int rr, input int gg, input int bb,
                                 input int shift, input int minc, input int stamp);
    exp_t e;
    int mx, mn, c, off, diff, q, h;
    longint unsigned raw;
    mx = rr; if (gg > mx) mx = gg; if (bb > mx) mx = bb;
    mn = rr; if (gg < mn) mn = gg; if (bb < mn) mn = bb;
    c  = mx - mn;
    if (rr >= gg && rr >= bb) begin off = 0;   diff = gg - bb; end
    else if (gg >= bb)        begin off = 120; diff = bb - rr; end
    else                      begin off = 240; diff = rr - gg; end
    if (c == 0) h = 0;
    else begin
      q = (60 * (diff < 0 ? -diff : diff)) / c;
      h = (diff < 0) ? off - q : off + q;
      if (h < 0) h += 360;
    end
    raw = longint'(c * mx) << shift;
    e.hue   = h;
    e.imp   = (c == 0 || c < minc) ? 64'd0 : (raw & 64'hFFFF_FFFF_FFFF);
    e.stamp = stamp;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    compared++;
    if (act !== expv) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, expv, $time);
    end
  endtask

  always @(posedge clk) begin
    if (!reset && ifa.in_valid && ifa.in_ready) begin
      exq_a.push_back(model(ifa.r, ifa.g, ifa.b, 0, 0, cyc));
      accq.push_back(cyc);
    end
    if (!reset && ifb.in_valid && ifb.in_ready)
      exq_b.push_back(model(ifb.r, ifb.g, ifb.b, 32, 16, cyc));
    cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (ifa.out_valid) begin
        if (exq_a.size() == 0) begin
          compared++; failed++;
          $display("FAIL a_unexpected_valid: got out_valid=1 expected 0 (t=%0t)", $time);
        end else begin
          e = exq_a.pop_front();
          chk("a_hue", 64'(ifa.hue), 64'(e.hue));
          chk("a_importance", 64'(ifa.importance), e.imp);
          chk("a_latency", 64'(cyc - e.stamp), 64'd17);
        end
      end else chk("a_idle_importance", 64'(ifa.importance), 64'd0);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (ifb.out_valid) begin
        if (exq_b.size() == 0) begin
          compared++; failed++;
          $display("FAIL b_unexpected_valid: got out_valid=1 expected 0 (t=%0t)", $time);
        end else begin
          e = exq_b.pop_front();
          chk("b_hue", 64'(ifb.hue), 64'(e.hue));
          chk("b_importance", 64'(ifb.importance), e.imp);
          chk("b_latency", 64'(cyc - e.stamp), 64'd17);
        end
      end else chk("b_idle_importance", 64'(ifb.importance), 64'd0);
    end
  end

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic send(input int which, input logic [7:0] rr, input logic [7:0] gg,
                      input logic [7:0] bb);
    int n;
    n = 0;
    if (which == 0) begin ifa.r = rr; ifa.g = gg; ifa.b = bb; ifa.in_valid = 1'b1; end
    else            begin ifb.r = rr; ifb.g = gg; ifb.b = bb; ifb.in_valid = 1'b1; end
    while (((which == 0) ? ifa.in_ready : ifb.in_ready) !== 1'b1 && n < 60) begin
      @(negedge clk); n++;
    end
    if (n >= 60) begin
      compared++; failed++;
      $display("FAIL accept_timeout: got in_ready=0 for %0d cycles expected 1", n);
    end
    @(negedge clk);
    if (which == 0) ifa.in_valid = 1'b0; else ifb.in_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] rr, gg, bb;
    int n;
    ifa.in_valid = 1'b0; ifa.r = '0; ifa.g = '0; ifa.b = '0;
    ifb.in_valid = 1'b0; ifb.r = '0; ifb.g = '0; ifb.b = '0;
    repeat (3) @(negedge clk);
    chk("reset_out_valid", 64'(ifa.out_valid), 64'd0);
    chk("reset_hue", 64'(ifa.hue), 64'd0);
    chk("reset_importance", 64'(ifa.importance), 64'd0);
    chk("reset_in_ready", 64'(ifa.in_ready), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_reset_in_ready", 64'(ifa.in_ready), 64'd1);

    // Directed pixels held back-to-back: each accepted in the previous output cycle.
    accq.delete();
    send(0, 8'd255, 8'd0,   8'd0);
    send(0, 8'd0,   8'd255, 8'd0);
    send(0, 8'd0,   8'd0,   8'd255);
    send(0, 8'd255, 8'd0,   8'd255);
    send(0, 8'd255, 8'd128, 8'd0);
    send(0, 8'd100, 8'd100, 8'd100);
    for (int i = 1; i < 6; i++)
      chk("back_to_back_spacing", 64'(accq[i] - accq[i-1]), 64'd17);

    // Parameterised instance: grey rejection threshold and full-width shift.
    send(1, 8'd10,  8'd0, 8'd0);
    send(1, 8'd255, 8'd0, 8'd0);
    send(1, 8'd20,  8'd4, 8'd0);
    send(1, 8'd15,  8'd0, 8'd0);
    for (int i = 0; i < 10; i++)
      send(1, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 40)));

    for (int i = 0; i < 40; i++) begin
      rr = 8'($urandom_range(0, 255));
      gg = 8'($urandom_range(0, 255));
      bb = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) begin gg = rr; bb = rr; end
      if ($urandom_range(0, 7) == 0) gg = rr;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(0, rr, gg, bb);
    end

    n = 0;
    while (exq_a.size() != 0 && n < 40) begin @(negedge clk); n++; end

    // Reset in the middle of a conversion abandons the pixel.
    send(0, 8'd10, 8'd200, 8'd30);
    repeat (7) @(negedge clk);
    reset = 1'b1;
    exq_a.delete();
    exq_b.delete();
    @(negedge clk);
    chk("midreset_out_valid", 64'(ifa.out_valid), 64'd0);
    chk("midreset_hue", 64'(ifa.hue), 64'd0);
    chk("midreset_importance", 64'(ifa.importance), 64'd0);
    chk("midreset_in_ready", 64'(ifa.in_ready), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("midreset_ready_after", 64'(ifa.in_ready), 64'd1);
    repeat (25) @(negedge clk);
    chk("midreset_hue_hold", 64'(ifa.hue), 64'd0);

    send(0, 8'd0, 8'd255, 8'd0);
    n = 0;
    while ((exq_a.size() != 0 || exq_b.size() != 0) && n < 100) begin
      @(negedge clk); n++;
    end
    if (n >= 100) begin
      compared++; failed++;
      $display("FAIL drain_timeout: got %0d outstanding expected 0", exq_a.size() + exq_b.size());
    end
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
